// File: rtl/seq_mul.sv
// Sequential shift-add multiplier, unsigned or two's-complement, with a start/busy/done handshake.
// Full 2*WIDTH product after WIDTH+2 cycles, plus a WIDTH-bit truncated result and overflow flag.
module seq_mul #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             sm_q;

  logic [WIDTH-1:0] x_mag_c, y_mag_c;
  logic             neg_c;
  logic             last_c;
  logic [PW-1:0]    prod_c;
  logic [WIDTH:0]   hi_c;
  logic             ovf_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_c) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes, sign fix-up and overflow detection
  always_comb begin
    x_mag_c = x;
    y_mag_c = y;
    if (signed_mode && x[WIDTH-1]) x_mag_c = WIDTH'(-x);
    if (signed_mode && y[WIDTH-1]) y_mag_c = WIDTH'(-y);
    neg_c  = signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
    last_c = (cnt_q == CW'(WIDTH - 1));
    prod_c = neg_q ? PW'(-acc_q) : acc_q;
    hi_c   = prod_c[PW-1:WIDTH-1];
    if (sm_q) ovf_c = !((&hi_c) || !(|hi_c));
    else      ovf_c = |prod_c[PW-1:WIDTH];
  end

  // Datapath: capture in IDLE, one shift-add per RUN cycle, register results in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sm_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= PW'(x_mag_c);
            mplier_q <= y_mag_c;
            neg_q    <= neg_c;
            sm_q     <= signed_mode;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= CW'(cnt_q + 1'b1);
        end
        FIX: begin
          product  <= prod_c;
          result   <= prod_c[WIDTH-1:0];
          overflow <= ovf_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: WIDTH=4 and WIDTH=8 instances, hand-computed products.
module tb_seq_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start4 = 1'b0, sm4 = 1'b0;
  logic [3:0] x4 = '0, y4 = '0;
  logic       busy4, done4, ovf4;
  logic [7:0] prod4;
  logic [3:0] res4;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        busy8, done8, ovf8;
  logic [15:0] prod8;
  logic [7:0]  res8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .product(prod4), .result(res4), .overflow(ovf4)
  );

  seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .product(prod8), .result(res8), .overflow(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=4 operation starting in the current cycle; ends in the done cycle.
  task automatic op4(input string tag, input logic sm, input logic [3:0] xv, input logic [3:0] yv,
                     input logic [7:0] ep, input logic eo, input logic [7:0] hold);
    start4 = 1'b1; sm4 = sm; x4 = xv; y4 = yv;
    tick();
    start4 = 1'b0;
    x4 = 4'($urandom); y4 = 4'($urandom); sm4 = 1'($urandom);
    for (int c = 1; c <= 5; c++) begin
      chk({tag, "_busy"}, 32'(busy4), 32'd1);
      chk({tag, "_nodone"}, 32'(done4), 32'd0);
      chk({tag, "_hold"}, 32'(prod4), 32'(hold));
      tick();
    end
    chk({tag, "_done"}, 32'(done4), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy4), 32'd0);
    chk({tag, "_product"}, 32'(prod4), 32'(ep));
    chk({tag, "_result"}, 32'(res4), 32'(ep[3:0]));
    chk({tag, "_overflow"}, 32'(ovf4), 32'(eo));
  endtask

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_product", 32'(prod4), 32'd0);
    chk("rst_result", 32'(res4), 32'd0);
    chk("rst_overflow", 32'(ovf4), 32'd0);
    rst = 1'b0;
    tick();

    op4("u3x5",   1'b0, 4'd3, 4'd5, 8'h0F, 1'b0, 8'h00);
    tick();
    op4("u15x15", 1'b0, 4'hF, 4'hF, 8'hE1, 1'b1, 8'h0F);
    tick();
    op4("sm2x3",  1'b1, 4'hE, 4'h3, 8'hFA, 1'b0, 8'hE1);
    tick();
    op4("sm8xm8", 1'b1, 4'h8, 4'h8, 8'h40, 1'b1, 8'hFA);
    tick();
    op4("s7xm1",  1'b1, 4'h7, 4'hF, 8'hF9, 1'b0, 8'h40);
    tick();

    // Start while busy is ignored
    start4 = 1'b1; sm4 = 1'b0; x4 = 4'd2; y4 = 4'd3;
    tick();                                   // cycle 1
    start4 = 1'b0;
    chk("ign_busy1", 32'(busy4), 32'd1);
    tick();                                   // cycle 2
    start4 = 1'b1; x4 = 4'd9; y4 = 4'd9;
    tick();                                   // cycle 3
    start4 = 1'b0;
    chk("ign_busy3", 32'(busy4), 32'd1);
    tick(); tick(); tick();                   // cycle 6
    chk("ign_done", 32'(done4), 32'd1);
    chk("ign_product", 32'(prod4), 32'h06);
    // Back-to-back: start held in the done cycle
    op4("b2b2x2", 1'b0, 4'd2, 4'd2, 8'h04, 1'b0, 8'h06);
    tick();

    // Reset mid-operation
    start4 = 1'b1; sm4 = 1'b0; x4 = 4'd3; y4 = 4'd5;
    tick();                                   // cycle 1
    start4 = 1'b0;
    tick(); tick();                           // cycle 3
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_done", 32'(done4), 32'd0);
    chk("abort_product", 32'(prod4), 32'd0);
    chk("abort_result", 32'(res4), 32'd0);
    chk("abort_overflow", 32'(ovf4), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("abort_nodone", 32'(done4), 32'd0);
      tick();
    end
    op4("post_rst3x5", 1'b0, 4'd3, 4'd5, 8'h0F, 1'b0, 8'h00);
    tick();

    // WIDTH=8 unsigned 255*255
    start8 = 1'b1; sm8 = 1'b0; x8 = 8'hFF; y8 = 8'hFF;
    tick();
    start8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
    for (int c = 1; c <= 9; c++) begin
      chk("w8_busy", 32'(busy8), 32'd1);
      chk("w8_nodone", 32'(done8), 32'd0);
      tick();
    end
    chk("w8_done", 32'(done8), 32'd1);
    chk("w8_busy_lo", 32'(busy8), 32'd0);
    chk("w8_product", 32'(prod8), 32'hFE01);
    chk("w8_result", 32'(res8), 32'h01);
    chk("w8_overflow", 32'(ovf8), 32'd1);
    tick();
    chk("w8_done_pulse", 32'(done8), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised sequential shift-add multiplier for the calculator datapath, replacing the fixed 4-bit combinational multiply. It accepts two WIDTH-bit operands on a start pulse and computes the full 2*WIDTH-bit product over WIDTH+2 cycles, in unsigned or two's-complement mode. It also provides a WIDTH-bit truncated result with an overflow flag for the display path. A start/busy/done handshake lets the calculator control FSM sequence operations.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..16.
- clk  input  1  rising-edge clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while the block is idle or in the done cycle.
- signed_mode  input  1  captured with start; 1 = two's-complement, 0 = unsigned.
- x  input  WIDTH  multiplicand, captured with start.
- y  input  WIDTH  multiplier, captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product, result and overflow are valid from this cycle.
- product  output  2*WIDTH  full product; signed in signed mode.
- result  output  WIDTH  product[WIDTH-1:0].
- overflow  output  1  the product does not fit in WIDTH bits in the captured mode.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Capture the operand magnitudes. In signed mode with a negative operand, the magnitude is its two's-complement negation, taken as a WIDTH-bit unsigned value; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Capture neg = sign(x) XOR sign(y) in signed mode, else 0.
  - Clear the 2*WIDTH-bit accumulator and the iteration counter. Go to RUN.
- RUN: one iteration per cycle, WIDTH iterations.
  - If bit i of the multiplier magnitude is 1, add (multiplicand magnitude << i) into the accumulator.
  - Any equivalent shift-register formulation is acceptable if the cycle count is unchanged.
  - After iteration WIDTH-1, go to FIX.
- FIX:
  - Register product = neg ? -acc : acc, truncated to 2*WIDTH bits.
  - Register result and overflow from that product.
  - Pulse done. Go to IDLE.
- Overflow, unsigned mode: product[2*WIDTH-1:WIDTH] != 0.
- Overflow, signed mode: product[2*WIDTH-1:WIDTH-1] is not all-zeros and not all-ones.
- The full product always fits in 2*WIDTH bits in both modes; -2^(W-1) * -2^(W-1) = 2^(2W-2) is representable.
- start while busy=1 is ignored. Operands are not re-captured and no error is flagged.
- x, y and signed_mode may change freely after the capture cycle without affecting the operation.
- product, result and overflow hold their values until the next FIX cycle.

## Timing
- Reset values: busy=0, done=0, product=0, result=0, overflow=0; state=IDLE; accumulator and counter cleared.
- rst has priority over all other inputs on the same edge.
- Reset mid-operation aborts the operation. No done is produced and the outputs return to 0.
- Let cycle 0 be the cycle in which start is sampled high in IDLE:
  - busy is high in cycles 1 through WIDTH+1.
  - done is high in cycle WIDTH+2 only; busy is low in that cycle.
  - Total latency is WIDTH+2 cycles, so 6 cycles at WIDTH=4.
- Back-to-back: start high in the done cycle is accepted, because the state is IDLE. This gives a throughput of one operation per WIDTH+2 cycles.
- done and busy are never high in the same cycle.

## Test plan
- WIDTH=4, unsigned, x=3, y=5, start for 1 cycle -> busy high in cycles 1–5; done in cycle 6 with product=8'h0F, result=4'hF, overflow=0.
- WIDTH=4, unsigned, x=15, y=15 -> product=8'hE1, result=4'h1, overflow=1.
- WIDTH=4, signed:
  - x=4'hE (-2), y=4'h3 -> product=8'hFA (-6), result=4'hA, overflow=0.
  - x=4'h8, y=4'h8 (-8*-8) -> product=8'h40, overflow=1.
  - x=4'h7, y=4'hF (7*-1) -> product=8'hF9, overflow=0.
- WIDTH=4, unsigned 2*3 in progress, start pulsed in cycle 2 with x=9, y=9 -> ignored; done in cycle 6 with product=8'h06.
  - Then, with start held high in the done cycle with x=4'h2, y=4'h2 -> second done 6 cycles later with product=8'h04.
- Reset mid-operation, then WIDTH=8:
  - Assert rst in cycle 3 of an operation -> done never pulses; all outputs read 0 the cycle after rst; a following start completes normally.
  - WIDTH=8, unsigned 255*255 -> product=16'hFE01, overflow=1, done in cycle 10.
